// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_WAIT = 2'd1,
        IFQ_DROP = 2'd2
    } ifq_state_e;

    localparam int PC_STEP    = 4;
    localparam int IFQ_ADDR_W = 32;
    localparam int IFQ_DATA_W = 32;

    // Layout of one queue entry at the default widths; the FIFO stores {pc, inst} in this order.
    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Ring-buffer FIFO with flush and a registered head that holds its last value when empty.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic [W-1:0]     head_o
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [W-1:0]     head_q;

    assign rd_nxt    = rd_ptr + PTR_W'(pop_i);
    assign count_nxt = count + CNT_W'(push_i) - CNT_W'(pop_i);

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            // The new head is the incoming word only when nothing older survives this edge.
            if (count_nxt != '0) begin
                head_q <= (push_i && (count == CNT_W'(pop_i))) ? din_i : mem[rd_nxt];
            end
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign head_o  = head_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential fetch with one outstanding request, {pc,inst} FIFO, redirect flush.
// Define IFQ_BYPASS_EN to let an ack reach inst_* in the same cycle when the FIFO is empty.
module if_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    output logic                    imem_req_o,
    output logic [ADDR_W-1:0]       imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [DATA_W-1:0]       imem_data_i,
    output logic                    inst_valid_o,
    input  logic                    inst_ready_i,
    output logic [DATA_W-1:0]       inst_o,
    output logic [ADDR_W-1:0]       pc_o,
    output logic [1:0]              dbg_state_o,
    output logic [$clog2(DEPTH):0]  dbg_count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = ADDR_W + DATA_W;

    ifq_state_e        state_q;
    ifq_state_e        state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic [CNT_W:0]    occupancy;
    logic              issue_ok;
    logic              ack_take;
    logic              push;
    logic              pop;

    // The in-flight request reserves a slot, so a push can never find the FIFO full.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state_q != IFQ_IDLE)};
    assign issue_ok  = start_i & ~redirect_i & (occupancy < (CNT_W+1)'(DEPTH));
    assign ack_take  = (state_q == IFQ_WAIT) & imem_ack_i & ~redirect_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IFQ_IDLE: if (issue_ok) state_d = IFQ_WAIT;
            IFQ_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_ack_i ? IFQ_IDLE : IFQ_DROP;
                end else if (imem_ack_i) begin
                    state_d = IFQ_IDLE;
                end
            end
            IFQ_DROP: if (imem_ack_i) state_d = IFQ_IDLE;
            default:  state_d = IFQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IFQ_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc_i;
            end else if (ack_take) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    assign imem_req_o  = (state_q == IFQ_WAIT);
    assign imem_addr_o = fetch_pc_q;

    // Handshake: an entry transfers on a rising edge where inst_valid_o and inst_ready_i are both 1;
    // inst_valid_o never depends on inst_ready_i and is held low during redirect.
    assign pop = ~fifo_empty & ~redirect_i & inst_ready_i;

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit   = fifo_empty & ack_take;
    assign inst_valid_o = bypass_hit | (~fifo_empty & ~redirect_i);
    assign inst_o       = bypass_hit ? imem_data_i : fifo_head[DATA_W-1:0];
    assign pc_o         = bypass_hit ? fetch_pc_q : fifo_head[EW-1 -: ADDR_W];
    assign push         = ack_take & ~(bypass_hit & inst_ready_i);
`else
    assign inst_valid_o = ~fifo_empty & ~redirect_i;
    assign inst_o       = fifo_head[DATA_W-1:0];
    assign pc_o         = fifo_head[EW-1 -: ADDR_W];
    assign push         = ack_take;
`endif

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   ({fetch_pc_q, imem_data_i}),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign dbg_state_o = state_q;
    assign dbg_count_o = fifo_count;

endmodule
